// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier returning the low XLEN bits of op_a*op_b.
// All additions and the termination test go through the shared ALU; only the shifts are local.
module alu_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;

  // Control sequencing and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_acc    <= {XLEN{1'b0}};
      r_mcand  <= {XLEN{1'b0}};
      r_mplier <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= {XLEN{1'b0}};
            r_state  <= S_CHECK;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        // mplier OR mplier is zero exactly when every multiplier bit is consumed.
        S_CHECK: begin
          if (alu_zero) begin
            r_state <= S_DONE;
          end else if (r_mplier[0]) begin
            r_state <= S_ADD;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_ADD: begin
          r_acc   <= alu_result;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_state  <= S_CHECK;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and ALU request decode; no path from alu_result back to the ALU operands.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    alu_req     = 1'b0;
    alu_a       = {XLEN{1'b0}};
    alu_b       = {XLEN{1'b0}};
    alu_control = ALU_NOP;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_CHECK: begin
        busy        = 1'b1;
        alu_req     = 1'b1;
        alu_a       = r_mplier;
        alu_b       = r_mplier;
        alu_control = ALU_OR;
      end
      S_ADD: begin
        busy        = 1'b1;
        alu_req     = 1'b1;
        alu_a       = r_acc;
        alu_b       = r_mcand;
        alu_control = ALU_ADD;
      end
      S_SHIFT: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign product = r_acc;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU attached to its ALU port.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;

  alu_mul_seq #(.XLEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .alu_req     (alu_req),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Behavioural ALU: OR and ADD are the only ops the multiplier uses.
  always_comb begin
    case (alu_control)
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          nchk;
    int          nadd;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int popcnt(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += v[i];
    return n;
  endfunction

  function automatic int msb_pos(input logic [31:0] v);
    int m = -1;
    for (int i = 0; i < 32; i++) if (v[i]) m = i;
    return m;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int set;
    int clr;
    if (b == 32'd0) return 2;
    set = popcnt(b);
    clr = msb_pos(b) + 1 - set;
    return 2 + 3 * set + 2 * clr;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: per-op activity counters, checked against the scoreboard on done.
  int busy_cnt  = 0;
  int or_cnt    = 0;
  int add_cnt   = 0;
  int idle_viol = 0;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      busy_cnt = 0; or_cnt = 0; add_cnt = 0; idle_viol = 0;
    end else begin
      if (busy) busy_cnt++;
      if (alu_control == 3'b001) or_cnt++;
      if (alu_control == 3'b010) add_cnt++;
      if (!alu_req && (alu_a != 32'd0 || alu_b != 32'd0 || alu_control != 3'b000)) idle_viol++;
      if (done) begin
        check_eq("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("product",    product,          e.prod);
          check_eq("latency",    cyc - e.t0,       e.lat);
          check_eq("busy_cycles", busy_cnt,        e.lat);
          check_eq("check_count", or_cnt,          e.nchk);
          check_eq("add_count",   add_cnt,         e.nadd);
          check_eq("alu_idle_zero", idle_viol,     32'd0);
        end
        busy_cnt = 0; or_cnt = 0; add_cnt = 0; idle_viol = 0;
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    e.prod = a * b;
    e.lat  = exp_lat(b);
    e.nchk = (b == 32'd0) ? 1 : msb_pos(b) + 2;
    e.nadd = popcnt(b);
    e.t0   = cyc;
    exp_q.push_back(e);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    p = a * b;
    start_op(a, b);
    wait_done();
    @(negedge clk);
    check_eq("prod_hold", product, p);
    check_eq("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_add();
    int n = 0;
    @(negedge clk);
    while (alu_control != 3'b010 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (alu_control != 3'b010) check_eq("add_timeout", {29'd0, alu_control}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=0x%08h exp=0x%08h", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op_a    = 32'd0;
    op_b    = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",    {31'd0, busy},    32'd0);
    check_eq("rst_done",    {31'd0, done},    32'd0);
    check_eq("rst_alu_req", {31'd0, alu_req}, 32'd0);
    check_eq("rst_product", product,          32'd0);
    check_eq("rst_alu_ctl", {29'd0, alu_control}, 32'd0);
    reset_n = 1'b1;

    run_op(32'd6, 32'd7);
    run_op(32'd12345, 32'd0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(32'h00010000, 32'h00010000);
    run_op(32'd0, 32'h80000001);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom_range(0, 4095));
    run_op($urandom, $urandom);

    // Starts while busy and in the DONE cycle must be ignored.
    start_op(32'd6, 32'd7);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op_a = 32'd100; op_b = 32'd100;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    wait_done();
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("ignored_start_busy", {31'd0, busy}, 32'd0);
    check_eq("ignored_start_prod", product, 32'd42);

    // Reset asserted during the second ADD of 5x9 aborts without done.
    start_op(32'd5, 32'd9);
    wait_add();
    wait_add();
    check_eq("pre_reset_acc", product, 32'd5);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("abort_busy",    {31'd0, busy},    32'd0);
    check_eq("abort_done",    {31'd0, done},    32'd0);
    check_eq("abort_alu_req", {31'd0, alu_req}, 32'd0);
    check_eq("abort_product", product,          32'd0);
    check_eq("abort_alu_a",   alu_a,            32'd0);
    check_eq("abort_alu_b",   alu_b,            32'd0);
    check_eq("abort_alu_ctl", {29'd0, alu_control}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op(32'd3, 32'd4);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
